// File: rtl/blast_hit_topk.sv
// Result stage for the BLAST hit stream: keeps the DEPTH best hits sorted by
// score during a scan, then streams them out best-first over valid/ready.
module blast_hit_topk #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 32,
    parameter int SCORE_W   = 11,
    parameter int MIN_SCORE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       newSearch,
    input  logic                       hitValid,
    input  logic [ADDR_W-1:0]          locationStart,
    input  logic [ADDR_W-1:0]          locationEnd,
    input  logic [SCORE_W-1:0]         highestScore,
    input  logic                       processEnd,
    output logic                       hitReady,
    output logic                       outValid,
    input  logic                       outReady,
    output logic [ADDR_W-1:0]          outStart,
    output logic [ADDR_W-1:0]          outEnd,
    output logic [SCORE_W-1:0]         outScore,
    output logic [$clog2(DEPTH)-1:0]   outRank,
    output logic                       outLast,
    output logic                       done,
    output logic [15:0]                hitCount,
    output logic [15:0]                evictCount
);

    // state     | meaning
    // S_COLLECT | accepting hits into the sorted table
    // S_DRAIN   | streaming table entries, best first
    // S_DONE    | stream finished, table and counters held
    typedef enum logic [1:0] {S_COLLECT, S_DRAIN, S_DONE} state_t;

    localparam int RANK_W = $clog2(DEPTH);
    localparam int CNT_W  = RANK_W + 1;
    // Leading 1 on both sides keeps the threshold compare non-trivial when MIN_SCORE is 0.
    localparam logic [SCORE_W:0] MIN_EXT = {1'b1, SCORE_W'(MIN_SCORE)};

    state_t                state_q, state_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [ADDR_W-1:0]     start_q [DEPTH];
    logic [ADDR_W-1:0]     start_d [DEPTH];
    logic [ADDR_W-1:0]     end_q   [DEPTH];
    logic [ADDR_W-1:0]     end_d   [DEPTH];
    logic [SCORE_W-1:0]    score_q [DEPTH];
    logic [SCORE_W-1:0]    score_d [DEPTH];
    logic [RANK_W-1:0]     idx_q, idx_d;
    logic [15:0]           hit_cnt_q, hit_cnt_d;
    logic [15:0]           evict_cnt_q, evict_cnt_d;

    logic [DEPTH-1:0]      ge;
    logic [CNT_W-1:0]      valid_cnt;
    logic                  score_ok;
    logic                  accept;
    logic                  last_idx;

    always_comb begin
        valid_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ge[i]     = valid_q[i] && (score_q[i] >= highestScore);
            valid_cnt = valid_cnt + CNT_W'(valid_q[i]);
        end
        score_ok = ({1'b1, highestScore} >= MIN_EXT);
        accept   = hitValid && score_ok && (state_q == S_COLLECT);
        last_idx = ({1'b0, idx_q} == (valid_cnt - CNT_W'(1)));
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        start_d     = start_q;
        end_d       = end_q;
        score_d     = score_q;
        idx_d       = idx_q;
        hit_cnt_d   = hit_cnt_q;
        evict_cnt_d = evict_cnt_q;

        if (newSearch) begin
            valid_d     = '0;
            hit_cnt_d   = '0;
            evict_cnt_d = '0;
            idx_d       = '0;
            state_d     = S_COLLECT;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (accept) begin
                        if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
                        // Table sorted and packed: a full table always loses one hit.
                        if (valid_q[DEPTH-1] && evict_cnt_q != 16'hFFFF)
                            evict_cnt_d = evict_cnt_q + 16'd1;
                        if (!ge[0]) begin
                            valid_d[0] = 1'b1;
                            start_d[0] = locationStart;
                            end_d[0]   = locationEnd;
                            score_d[0] = highestScore;
                        end
                        for (int i = 1; i < DEPTH; i++) begin
                            if (!ge[i]) begin
                                if (ge[i-1]) begin
                                    valid_d[i] = 1'b1;
                                    start_d[i] = locationStart;
                                    end_d[i]   = locationEnd;
                                    score_d[i] = highestScore;
                                end else begin
                                    valid_d[i] = valid_q[i-1];
                                    start_d[i] = start_q[i-1];
                                    end_d[i]   = end_q[i-1];
                                    score_d[i] = score_q[i-1];
                                end
                            end
                        end
                    end
                    if (processEnd) begin
                        idx_d   = '0;
                        state_d = valid_d[0] ? S_DRAIN : S_DONE;
                    end
                end
                S_DRAIN: begin
                    if (outReady) begin
                        if (last_idx) state_d = S_DONE;
                        else          idx_d   = idx_q + RANK_W'(1);
                    end
                end
                S_DONE:  ;
                default: state_d = S_COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_COLLECT;
            valid_q     <= '0;
            idx_q       <= '0;
            hit_cnt_q   <= '0;
            evict_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                start_q[i] <= '0;
                end_q[i]   <= '0;
                score_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            start_q     <= start_d;
            end_q       <= end_d;
            score_q     <= score_d;
            idx_q       <= idx_d;
            hit_cnt_q   <= hit_cnt_d;
            evict_cnt_q <= evict_cnt_d;
        end
    end

    assign hitReady   = (state_q == S_COLLECT);
    assign outValid   = (state_q == S_DRAIN);
    assign done       = (state_q == S_DONE);
    assign outStart   = outValid ? start_q[idx_q] : '0;
    assign outEnd     = outValid ? end_q[idx_q]   : '0;
    assign outScore   = outValid ? score_q[idx_q] : '0;
    assign outRank    = outValid ? idx_q          : '0;
    assign outLast    = outValid && last_idx;
    assign hitCount   = hit_cnt_q;
    assign evictCount = evict_cnt_q;

endmodule

// File: tb/tb_blast_hit_topk.sv
// Directed bench for blast_hit_topk: one DUT with MIN_SCORE=0, one with MIN_SCORE=3,
// both driven by the same stimulus.
module tb_blast_hit_topk;

    logic        clk = 1'b0;
    logic        rst, newSearch, hitValid, processEnd, outReady;
    logic [31:0] locationStart, locationEnd;
    logic [10:0] highestScore;

    logic        hit_ready, out_valid, out_last, done_o;
    logic [31:0] out_start, out_end;
    logic [10:0] out_score;
    logic [1:0]  out_rank;
    logic [15:0] hit_count, evict_count;

    logic        hit_ready2, out_valid2, out_last2, done2;
    logic [31:0] out_start2, out_end2;
    logic [10:0] out_score2;
    logic [1:0]  out_rank2;
    logic [15:0] hit_count2, evict_count2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    blast_hit_topk #(.DEPTH(4), .ADDR_W(32), .SCORE_W(11), .MIN_SCORE(0)) dut (
        .clk(clk), .rst(rst), .newSearch(newSearch), .hitValid(hitValid),
        .locationStart(locationStart), .locationEnd(locationEnd), .highestScore(highestScore),
        .processEnd(processEnd), .hitReady(hit_ready), .outValid(out_valid), .outReady(outReady),
        .outStart(out_start), .outEnd(out_end), .outScore(out_score), .outRank(out_rank),
        .outLast(out_last), .done(done_o), .hitCount(hit_count), .evictCount(evict_count)
    );

    blast_hit_topk #(.DEPTH(4), .ADDR_W(32), .SCORE_W(11), .MIN_SCORE(3)) dut_min (
        .clk(clk), .rst(rst), .newSearch(newSearch), .hitValid(hitValid),
        .locationStart(locationStart), .locationEnd(locationEnd), .highestScore(highestScore),
        .processEnd(processEnd), .hitReady(hit_ready2), .outValid(out_valid2), .outReady(outReady),
        .outStart(out_start2), .outEnd(out_end2), .outScore(out_score2), .outRank(out_rank2),
        .outLast(out_last2), .done(done2), .hitCount(hit_count2), .evictCount(evict_count2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hit(input logic v, input int score, input int start);
        hitValid      = v;
        highestScore  = 11'(score);
        locationStart = 32'(start);
        locationEnd   = 32'(start + 16);
    endtask

    task automatic beat(input string tag, input int score, input int start, input int rank,
                        input logic last);
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".score"}, 64'(out_score), 64'(score));
        chk({tag, ".start"}, 64'(out_start), 64'(start));
        chk({tag, ".end"},   64'(out_end),   64'(start + 16));
        chk({tag, ".rank"},  64'(out_rank),  64'(rank));
        chk({tag, ".last"},  64'(out_last),  64'(last));
    endtask

    task automatic new_search();
        newSearch = 1'b1;
        step();
        newSearch = 1'b0;
    endtask

    initial begin
        rst = 1'b1; newSearch = 1'b0; processEnd = 1'b0; outReady = 1'b0;
        set_hit(1'b0, 0, 0);
        step(); step();
        rst = 1'b0;
        step();

        // reset state
        chk("rst.hitReady", 64'(hit_ready), 64'd1);
        chk("rst.outValid", 64'(out_valid), 64'd0);
        chk("rst.done", 64'(done_o), 64'd0);
        chk("rst.hitCount", 64'(hit_count), 64'd0);
        chk("rst.evictCount", 64'(evict_count), 64'd0);
        chk("rst.outScore", 64'(out_score), 64'd0);
        chk("rst.outLast", 64'(out_last), 64'd0);

        // empty scan goes straight to DONE
        processEnd = 1'b1;
        step();
        processEnd = 1'b0;
        chk("empty.done", 64'(done_o), 64'd1);
        chk("empty.outValid", 64'(out_valid), 64'd0);
        chk("empty.hitReady", 64'(hit_ready), 64'd0);
        new_search();
        chk("ns.done", 64'(done_o), 64'd0);
        chk("ns.hitReady", 64'(hit_ready), 64'd1);

        // back-to-back hits with a tie
        set_hit(1'b1, 5, 32'h100); step();
        set_hit(1'b1, 9, 32'h200); step();
        set_hit(1'b1, 7, 32'h300); step();
        set_hit(1'b1, 9, 32'h400); step();
        set_hit(1'b0, 0, 0);
        processEnd = 1'b1;
        step();
        processEnd = 1'b0;
        outReady = 1'b1;
        beat("tie0", 9, 32'h200, 0, 1'b0); step();
        beat("tie1", 9, 32'h400, 1, 1'b0); step();
        beat("tie2", 7, 32'h300, 2, 1'b0); step();
        beat("tie3", 5, 32'h100, 3, 1'b1); step();
        outReady = 1'b0;
        chk("tie.done", 64'(done_o), 64'd1);
        chk("tie.outValid", 64'(out_valid), 64'd0);
        chk("tie.hitCount", 64'(hit_count), 64'd4);
        chk("tie.evictCount", 64'(evict_count), 64'd0);

        // overflow: six ascending hits, then a low hit while full
        new_search();
        for (int s = 1; s <= 6; s++) begin
            set_hit(1'b1, s, s * 32'h10);
            step();
        end
        set_hit(1'b0, 0, 0);
        chk("ovf.evictCount", 64'(evict_count), 64'd2);
        chk("ovf.hitCount", 64'(hit_count), 64'd6);
        set_hit(1'b1, 0, 32'h999); step();
        set_hit(1'b0, 0, 0);
        chk("ovf0.evictCount", 64'(evict_count), 64'd3);
        chk("ovf0.hitCount", 64'(hit_count), 64'd7);
        processEnd = 1'b1;
        step();
        processEnd = 1'b0;
        outReady = 1'b1;
        beat("ovf_b0", 6, 32'h60, 0, 1'b0); step();
        beat("ovf_b1", 5, 32'h50, 1, 1'b0); step();
        beat("ovf_b2", 4, 32'h40, 2, 1'b0); step();
        beat("ovf_b3", 3, 32'h30, 3, 1'b1); step();
        outReady = 1'b0;
        chk("ovf.done", 64'(done_o), 64'd1);

        // MIN_SCORE threshold on the second instance
        new_search();
        set_hit(1'b1, 2, 32'h20); step();
        set_hit(1'b1, 4, 32'h40); step();
        set_hit(1'b0, 0, 0);
        chk("min.hitCount", 64'(hit_count2), 64'd1);
        chk("min.evictCount", 64'(evict_count2), 64'd0);
        chk("min.hitCount_ref", 64'(hit_count), 64'd2);
        processEnd = 1'b1;
        step();
        processEnd = 1'b0;
        outReady = 1'b1;
        chk("min.valid", 64'(out_valid2), 64'd1);
        chk("min.score", 64'(out_score2), 64'd4);
        chk("min.start", 64'(out_start2), 64'h40);
        chk("min.last", 64'(out_last2), 64'd1);
        beat("min_ref0", 4, 32'h40, 0, 1'b0);
        step();
        chk("min.done", 64'(done2), 64'd1);
        beat("min_ref1", 2, 32'h20, 1, 1'b1);
        step();
        outReady = 1'b0;
        chk("min_ref.done", 64'(done_o), 64'd1);

        // hit together with processEnd, then a stalled drain
        new_search();
        set_hit(1'b1, 3, 32'h300); step();
        set_hit(1'b1, 8, 32'h800);
        processEnd = 1'b1;
        step();
        set_hit(1'b0, 0, 0);
        processEnd = 1'b0;
        outReady = 1'b1;
        beat("stall0", 8, 32'h800, 0, 1'b0); step();
        outReady = 1'b0;
        beat("stall1a", 3, 32'h300, 1, 1'b1); step();
        beat("stall1b", 3, 32'h300, 1, 1'b1); step();
        beat("stall1c", 3, 32'h300, 1, 1'b1);
        outReady = 1'b1;
        step();
        outReady = 1'b0;
        chk("stall.done", 64'(done_o), 64'd1);
        chk("stall.outValid", 64'(out_valid), 64'd0);
        chk("stall.hitCount", 64'(hit_count), 64'd2);

        // newSearch in the middle of a drain
        new_search();
        set_hit(1'b1, 7, 32'h700); step();
        set_hit(1'b1, 5, 32'h500); step();
        set_hit(1'b1, 3, 32'h300); step();
        set_hit(1'b0, 0, 0);
        processEnd = 1'b1;
        step();
        processEnd = 1'b0;
        outReady = 1'b1;
        beat("abort0", 7, 32'h700, 0, 1'b0); step();
        outReady = 1'b0;
        new_search();
        chk("abort.outValid", 64'(out_valid), 64'd0);
        chk("abort.hitReady", 64'(hit_ready), 64'd1);
        chk("abort.hitCount", 64'(hit_count), 64'd0);
        chk("abort.evictCount", 64'(evict_count), 64'd0);
        chk("abort.done", 64'(done_o), 64'd0);
        set_hit(1'b1, 2, 32'hA0); step();
        set_hit(1'b0, 0, 0);
        processEnd = 1'b1;
        step();
        processEnd = 1'b0;
        beat("single", 2, 32'hA0, 0, 1'b1);
        outReady = 1'b1;
        step();
        outReady = 1'b0;
        chk("single.done", 64'(done_o), 64'd1);
        chk("single.outValid", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
